// File: rtl/gate_sweep_ctrl.sv
// Truth-table sweep controller for a 2-input gate under test.
// Drives each vector, samples the gate output and records mismatches.
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECT_TT     = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_y,
    output logic       dut_a,
    output logic       dut_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    localparam bit NO_SETTLE = (SETTLE_CYCLES == 0);
    localparam logic [3:0] LAST_CNT =
        NO_SETTLE ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    state_t     w_first;
    logic [1:0] r_vec;
    logic [3:0] r_cnt;
    logic [2:0] r_err;
    logic [3:0] r_fail;
    logic       r_pass;
    logic       w_accept;
    logic       w_mism;
    logic [2:0] w_err_next;

    // With no settle time each vector lives in CHECK alone
    assign w_first    = NO_SETTLE ? CHECK : DRIVE;
    assign w_accept   = (r_state == IDLE) && start && !abort;
    assign w_mism     = (r_state == CHECK) && (dut_y != EXPECT_TT[r_vec]);
    assign w_err_next = r_err + {2'b00, w_mism};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        dut_a  = 1'b0;
        dut_b  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_next = w_first;
            end
            DRIVE: begin
                busy  = 1'b1;
                dut_a = r_vec[1];
                dut_b = r_vec[0];
                if (abort)                 w_next = IDLE;
                else if (r_cnt == LAST_CNT) w_next = CHECK;
            end
            CHECK: begin
                busy  = 1'b1;
                dut_a = r_vec[1];
                dut_b = r_vec[0];
                if (abort)               w_next = IDLE;
                else if (r_vec == 2'd3) w_next = DONE;
                else                    w_next = w_first;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec  <= 2'd0;
            r_cnt  <= 4'd0;
            r_err  <= 3'd0;
            r_fail <= 4'd0;
            r_pass <= 1'b0;
        end else begin
            r_cnt <= (r_state == DRIVE && w_next == DRIVE) ?
                     r_cnt + 4'd1 : 4'd0;
            if (w_accept) begin
                r_vec  <= 2'd0;
                r_err  <= 3'd0;
                r_fail <= 4'd0;
                r_pass <= 1'b0;
            end
            // A mismatch is recorded even if abort lands on the same edge
            if (w_mism) begin
                r_err         <= w_err_next;
                r_fail[r_vec] <= 1'b1;
            end
            if (r_state == CHECK && !abort) begin
                if (r_vec == 2'd3) r_pass <= (w_err_next == 3'd0);
                else               r_vec  <= r_vec + 2'd1;
            end
        end
    end

    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: sweep result table plus
// abort, reset and back-to-back corner sequences.
module tb_gate_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, start0, abort0;
    logic [2:0] mode;
    logic       y, a, b, busy, done, pass;
    logic [2:0] err;
    logic [3:0] fail;
    logic       y0, a0, b0, busy0, done0, pass0;
    logic [2:0] err0;
    logic [3:0] fail0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // 0 AND, 1 tied 1, 2 OR, 3 tied 0, 4 XOR, 5 NAND
    function automatic logic model(input logic [2:0] m,
                                   input logic ia, input logic ib);
        case (m)
            3'd0:    return ia & ib;
            3'd1:    return 1'b1;
            3'd2:    return ia | ib;
            3'd3:    return 1'b0;
            3'd4:    return ia ^ ib;
            default: return ~(ia & ib);
        endcase
    endfunction

    assign y  = model(mode, a, b);
    assign y0 = model(3'd0, a0, b0);

    gate_sweep_ctrl #(.SETTLE_CYCLES(2), .EXPECT_TT(4'b1000)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_y(y), .dut_a(a), .dut_b(b), .busy(busy), .done(done),
        .pass(pass), .err_count(err), .fail_vec(fail)
    );

    gate_sweep_ctrl #(.SETTLE_CYCLES(0), .EXPECT_TT(4'b1000)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .dut_y(y0), .dut_a(a0), .dut_b(b0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(err0), .fail_vec(fail0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [11:0] act,
                       input logic [11:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {busy, done, a, b}
    function automatic logic [3:0] ctl();
        return {busy, done, a, b};
    endfunction

    function automatic logic [7:0] res();
        return {pass, err, fail};
    endfunction

    task automatic run_sweep(input logic [2:0] m, input logic [2:0] e_err,
                             input logic [3:0] e_fail, input logic e_pass);
        logic [1:0] v;
        mode  = m;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            v = 2'((c - 1) / 3);
            chk("sweep_ctl", 12'(ctl()), {8'd0, 2'b10, v});
            step();
        end
        chk("done_ctl", 12'(ctl()), 12'b0100);
        chk("done_res", 12'(res()), {4'd0, e_pass, e_err, e_fail});
        step();
        chk("idle_ctl", 12'(ctl()), 12'b0000);
        step();
        chk("idle_hold", 12'(res()), {4'd0, e_pass, e_err, e_fail});
    endtask

    typedef struct {
        logic [2:0] m;
        logic [2:0] e_err;
        logic [3:0] e_fail;
        logic       e_pass;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{3'd0, 3'd0, 4'b0000, 1'b1};
        tbl[1] = '{3'd1, 3'd3, 4'b0111, 1'b0};
        tbl[2] = '{3'd2, 3'd2, 4'b0110, 1'b0};
        tbl[3] = '{3'd3, 3'd1, 4'b1000, 1'b0};
        tbl[4] = '{3'd4, 3'd3, 4'b1110, 1'b0};
        tbl[5] = '{3'd5, 3'd4, 4'b1111, 1'b0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; mode = 3'd0;
        #12;
        chk("rst_ctl", 12'(ctl()), 12'd0);
        chk("rst_res", 12'(res()), 12'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst", {4'd0, ctl(), 4'd0}, 12'd0);

        for (int i = 0; i < 6; i++)
            run_sweep(tbl[i].m, tbl[i].e_err, tbl[i].e_fail, tbl[i].e_pass);

        // abort in the first DRIVE cycle of vector 2
        mode = 3'd1; start = 1'b1; step(); start = 1'b0;
        for (int c = 1; c < 7; c++) step();
        chk("pre_abort", 12'(ctl()), 12'b1010);
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_ctl", 12'(ctl()), 12'b0000);
        chk("abort_res", 12'(res()), {4'd0, 1'b0, 3'd2, 4'b0011});
        for (int c = 0; c < 15; c++) begin
            chk("abort_nodone", {11'd0, done}, 12'd0);
            step();
        end

        // abort on the CHECK edge of a mismatching vector 0
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_chk", 12'(res()), {4'd0, 1'b0, 3'd1, 4'b0001});
        chk("abort_chk_ctl", 12'(ctl()), 12'b0000);

        // abort beats start in IDLE
        start = 1'b1; abort = 1'b1; step();
        start = 1'b0; abort = 1'b0;
        chk("abort_start", 12'(ctl()), 12'b0000);
        step();
        chk("abort_start2", 12'(ctl()), 12'b0000);

        // asynchronous reset mid-sweep
        start = 1'b1; step(); start = 1'b0;
        for (int c = 1; c < 5; c++) step();
        chk("pre_rst_err", {9'd0, err}, 12'd1);
        rst_n = 1'b0;
        #2;
        chk("async_ctl", 12'(ctl()), 12'd0);
        chk("async_res", 12'(res()), 12'd0);
        #2 rst_n = 1'b1;
        step();
        chk("rst_nodone", {11'd0, done}, 12'd0);
        run_sweep(3'd0, 3'd0, 4'b0000, 1'b1);

        // held start, zero settle: 4 busy, DONE, IDLE, repeat
        start0 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            case ((c - 1) % 6)
                0, 1, 2, 3:
                    chk("b2b", {8'd0, busy0, done0, a0, b0},
                        {8'd0, 2'b10, 2'((c - 1) % 6)});
                4: begin
                    chk("b2b_done", {8'd0, busy0, done0, a0, b0}, 12'b0100);
                    chk("b2b_res", {4'd0, pass0, err0, fail0},
                        {4'd0, 1'b1, 3'd0, 4'd0});
                end
                default:
                    chk("b2b_idle", {8'd0, busy0, done0, a0, b0}, 12'd0);
            endcase
        end
        start0 = 1'b0;
        step(); step();
        chk("b2b_stop", {10'd0, busy0, done0}, 12'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter SETTLE_CYCLES SHALL be: default 2, range 0..15, extra hold cycles per vector before sampling.
REQ-003 Parameter EXPECT_TT SHALL be: default 4'b1000, expected gate output indexed by vector {a,b} (AND truth table).
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port start  input  1  request a truth-table sweep; level-sampled in IDLE only.
REQ-007 Port abort  input  1  synchronous cancel of a running sweep.
REQ-008 Port dut_y  input  1  output of the 2-input gate under control.
REQ-009 Port dut_a  output  1  gate input a, equal to vec[1].
REQ-010 Port dut_b  output  1  gate input b, equal to vec[0].
REQ-011 Port busy  output  1  high while a sweep is in progress.
REQ-012 Port done  output  1  one-cycle pulse when a sweep completes normally.
REQ-013 Port pass  output  1  high when the last completed sweep had zero mismatches.
REQ-014 Port err_count  output  3  mismatch count of the current or last sweep, 0..4.
REQ-015 Port fail_vec  output  4  bit i set when vector i mismatched.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE, CHECK, DONE.
REQ-017 IDLE: start=1 and abort=0 at a clock edge SHALL move to DRIVE with vec=0, clear err_count, fail_vec and pass, and set busy=1 from the next cycle.
REQ-018 DRIVE: dut_a/dut_b SHALL hold vec; a settle counter SHALL count SETTLE_CYCLES cycles, then move to CHECK (SETTLE_CYCLES=0 goes straight to CHECK).
REQ-019 CHECK (1 cycle, vec still driven): dut_y SHALL be sampled on the closing edge and compared with EXPECT_TT[vec].
REQ-020 On a mismatch, err_count SHALL increment and fail_vec[vec] SHALL set.
REQ-021 Each vector SHALL therefore be held exactly SETTLE_CYCLES+1 cycles, in order 00, 01, 10, 11.
REQ-022 After CHECK of vec<3, the FSM SHALL go to DRIVE with vec+1; after CHECK of vec=3, it SHALL go to DONE.
REQ-023 Total busy time SHALL be 4*(SETTLE_CYCLES+1) cycles.
REQ-024 DONE (1 cycle): done=1, busy=0, dut_a=dut_b=0, pass=(err_count==0); the next state SHALL be IDLE.
REQ-025 pass, err_count and fail_vec SHALL hold their values in IDLE until the next accepted start.
REQ-026 start in DRIVE, CHECK or DONE SHALL be ignored; a start held continuously SHALL launch the next sweep from IDLE on the cycle after DONE.
REQ-027 abort in DRIVE or CHECK SHALL return the FSM to IDLE on the next edge with busy=0, dut_a=dut_b=0 and pass=0.
REQ-028 On abort, done SHALL NOT pulse, and err_count and fail_vec SHALL retain partial results.
REQ-029 An abort on the same edge as a CHECK mismatch SHALL still record that mismatch.
REQ-030 abort and start together in IDLE: abort SHALL win and no sweep starts.
REQ-031 abort in DONE SHALL be ignored.
REQ-032 dut_a and dut_b SHALL be 0 in IDLE and DONE.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE, vec=0, settle counter 0, and all outputs (dut_a, dut_b, busy, done, pass, err_count, fail_vec) to 0.
REQ-034 Reset mid-sweep SHALL discard the sweep without a done pulse.
REQ-035 The first start is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-036 Ideal AND model, SETTLE_CYCLES=2, 1-cycle start -> busy=1 for 12 cycles; dut_a/dut_b = 00,01,10,11 for 3 cycles each; done pulses in cycle 13; pass=1, err_count=0, fail_vec=0000.
REQ-037 dut_y tied to 1 -> err_count=3, fail_vec=4'b0111, pass=0.
REQ-038 OR-gate model with default EXPECT_TT -> err_count=2, fail_vec=4'b0110, pass=0.
REQ-039 abort asserted during vector 2 DRIVE -> busy=0 next cycle, no done pulse, dut_a=dut_b=0, pass=0, fail_vec bits 0..1 as recorded.
REQ-040 rst_n pulsed low mid-sweep -> all outputs 0 immediately, without waiting for clk; a start after release gives the REQ-036 result.
REQ-041 start held high for 30 cycles with SETTLE_CYCLES=0 -> back-to-back sweeps of 4 busy cycles, each followed by a 1-cycle DONE and a 1-cycle IDLE, with done pulses 6 cycles apart.
